program_sequencer: RTL and testbench

Upstream feeder for the simple processor. Holds a small writable program memory and a program counter, and drives the processor's DIN and run inputs one instruction word at a time. It waits for the processor's done before advancing to the next word. A run is started by a start pulse and ends after prog_len words, on abort, or on a done timeout.

---
 rtl/seq_pkg.sv | 12 +
 rtl/prog_rom.sv | 23 ++
 rtl/program_sequencer.sv | 95 +++++++++
 tb/tb_program_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM states, default sizes and timeout counter width for program_sequencer
package seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, PAUSE, ERROR} state_t;
  localparam int W_DEF = 16;
  localparam int AW_DEF = 5;
  localparam int DEPTH_DEF = 2 ** AW_DEF;
  localparam int TIMEOUT_DEF = 255;
  function automatic int tcw(input int timeout);
    return $clog2(timeout + 1);
  endfunction
  localparam int TCW_DEF = tcw(TIMEOUT_DEF);
endpackage

// File: rtl/prog_rom.sv
// prog_rom: single-port DEPTHxW program memory, synchronous write, registered write-first read
// Ports: clk; rst_n clears only the read register; we/re share addr; wdata in; rdata registered out.
module prog_rom import seq_pkg::*; #(
  parameter int W = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  // rdata only changes on a read, so it holds the last fetched word indefinitely
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= we ? wdata : mem[addr];
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: feeds a processor one program word per run strobe, waiting for done between words
// Ports: clk_50MHz, reset_n (async, active-low); start/abort pulses; prog_len words per run;
//        prog_we/prog_addr/prog_data load memory (IDLE/ERROR only); proc_done from processor;
//        DIN/run to processor; busy, prog_done pulse, sticky err, pc.
// Build option SEQ_STEP_EN: adds input step and a PAUSE state between words.
module program_sequencer import seq_pkg::*; #(
  parameter int W = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_50MHz,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   prog_len,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [W-1:0]  prog_data,
  input  logic          proc_done,
`ifdef SEQ_STEP_EN
  input  logic          step,
`endif
  output logic [W-1:0]  DIN,
  output logic          run,
  output logic          busy,
  output logic          prog_done,
  output logic          err,
  output logic [AW-1:0] pc
);
  localparam int TW = tcw(TIMEOUT);
`ifdef SEQ_STEP_EN
  localparam state_t NEXT_WORD = PAUSE;
`else
  localparam state_t NEXT_WORD = FETCH;
`endif
  state_t state, nxt;
  logic [AW:0] len;
  logic [TW-1:0] cnt;
  logic idle_like, accept, last, timeout, mem_we, advance;
  assign idle_like = state == IDLE || state == ERROR;
  assign accept = idle_like && start && !abort;
  assign last = {1'b0, pc} == len - 1'b1;
  assign timeout = cnt == TW'(TIMEOUT);
  assign mem_we = prog_we && idle_like;
  assign advance = state == WAIT && proc_done && !abort && !last;
  assign busy = state != IDLE;
  // DIN is the memory read register: loaded only in FETCH, so it is valid in ISSUE and held afterwards
  prog_rom #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_rom (
    .clk(clk_50MHz),
    .rst_n(reset_n),
    .we(mem_we),
    .re(state == FETCH),
    .addr(mem_we ? prog_addr : pc),
    .wdata(prog_data),
    .rdata(DIN)
  );
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE, ERROR: nxt = accept ? (prog_len == '0 ? IDLE : FETCH) : state;
        FETCH:       nxt = ISSUE;
        ISSUE:       nxt = WAIT;
        WAIT:        nxt = proc_done ? (last ? IDLE : NEXT_WORD) : timeout ? ERROR : WAIT;
`ifdef SEQ_STEP_EN
        PAUSE:       nxt = step ? FETCH : PAUSE;
`endif
        default:     nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk_50MHz or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      len <= '0;
      pc <= '0;
      cnt <= '0;
      run <= 1'b0;
      prog_done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      run <= state == FETCH && nxt == ISSUE;
      prog_done <= (accept && prog_len == '0) || (state == WAIT && proc_done && last && !abort);
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (accept) begin
        len <= prog_len;
        pc <= '0;
        err <= 1'b0;
      end
      if (advance) pc <= pc + 1'b1;
      if (state == WAIT && nxt == ERROR) err <= 1'b1;
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: randomized scoreboard bench for program_sequencer with a word-list reference model
module tb_program_sequencer;
  localparam int W = 16;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int TIMEOUT = 255;
  typedef struct packed {logic is_done; logic [W-1:0] data;} ev_t;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, prog_we = 1'b0, proc_done = 1'b0;
  logic [AW:0] prog_len = '0;
  logic [AW-1:0] prog_addr = '0;
  logic [W-1:0] prog_data = '0;
  logic [W-1:0] DIN;
  logic run, busy, prog_done, err;
  logic [AW-1:0] pc;
`ifdef SEQ_STEP_EN
  logic step = 1'b0;
  int st_cnt = 0;
`endif
  ev_t q[$];
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] last_din = '0;
  int checks = 0, errors = 0, cyc = 0, run_cnt = 0, done_cnt = 0, run_cyc = -1;
  int trig_cyc = -1, done_trig = -1, lat = 4, pd_cnt = -1;
  bit resp_en = 1'b1, prev_run = 1'b0, hold_v = 1'b0;

  program_sequencer #(.W(W), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_50MHz(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .prog_len(prog_len),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .proc_done(proc_done),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .DIN(DIN),
    .run(run),
    .busy(busy),
    .prog_done(prog_done),
    .err(err),
    .pc(pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Processor model: one-cycle proc_done lat cycles after each run; a run is due 2 cycles after the trigger
  always @(negedge clk) begin
    proc_done = 1'b0;
`ifdef SEQ_STEP_EN
    step = 1'b0;
`endif
    if (!reset_n) begin
      pd_cnt = -1;
`ifdef SEQ_STEP_EN
      st_cnt = 0;
`endif
    end else begin
      if (run && resp_en) pd_cnt = lat;
      else if (pd_cnt == 1) begin
        proc_done = 1'b1;
        pd_cnt = -1;
        done_trig = cyc;
        if (q.size() > 0 && !q[0].is_done) begin
`ifdef SEQ_STEP_EN
          st_cnt = 2 + $urandom_range(0, 3);
`else
          trig_cyc = cyc;
`endif
        end
      end else if (pd_cnt > 1) pd_cnt--;
`ifdef SEQ_STEP_EN
      if (st_cnt == 1) begin
        step = 1'b1;
        trig_cyc = cyc;
      end
      if (st_cnt > 0) st_cnt--;
`endif
    end
  end

  // Monitor: pops the scoreboard on every run / prog_done and checks timing and DIN stability
  always @(negedge clk) begin : mon
    ev_t e;
    if (!reset_n) begin
      prev_run = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (run) begin
        run_cnt++;
        run_cyc = cyc;
        checks++;
        if (prev_run || trig_cyc < 0 || cyc - trig_cyc != 2) begin
          errors++;
          $display("FAIL run_timing cycle=%0d trigger=%0d prev_run=%0b required: trigger+2, single-cycle", cyc, trig_cyc, prev_run);
        end
        trig_cyc = -1;
        checks++;
        if (q.size() == 0 || q[0].is_done) begin
          errors++;
          $display("FAIL run_unexpected DIN=%0h queued=%0d required: no run", DIN, q.size());
        end else begin
          e = q.pop_front();
          checks++;
          if (DIN !== e.data) begin
            errors++;
            $display("FAIL din actual=%0h expected=%0h", DIN, e.data);
          end
        end
        last_din = DIN;
        hold_v = 1'b1;
      end else if (busy && hold_v) begin
        checks++;
        if (DIN !== last_din) begin
          errors++;
          $display("FAIL din_hold actual=%0h expected=%0h", DIN, last_din);
        end
      end
      if (prog_done) begin
        done_cnt++;
        checks++;
        if (q.size() == 0 || !q[0].is_done || cyc - done_trig != 1) begin
          errors++;
          $display("FAIL prog_done_unexpected cycle=%0d trigger=%0d queued=%0d", cyc, done_trig, q.size());
        end else void'(q.pop_front());
      end
      prev_run = run;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_mem(input int a, input logic [W-1:0] d, input bit model);
    prog_we = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    if (model) mem[a] = d;
  endtask

  task automatic launch(input int len);
    prog_len = (AW + 1)'(len);
    start = 1'b1;
    if (len == 0) done_trig = cyc;
    else begin
      for (int i = 0; i < len; i++) q.push_back('{1'b0, mem[i]});
      trig_cyc = cyc;
    end
    q.push_back('{1'b1, {W{1'b0}}});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_in_budget"}, busy, 0);
    tick(2);
    chk({name, "_queue_empty"}, q.size(), 0);
    q.delete();
  endtask

  task automatic wait_runs(input string name, input int target, input int budget);
    int n = 0;
    while (run_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_run_seen"}, run_cnt, target);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int r0, d0, rc, len;
    #12;
    chk("rst_DIN", DIN, 0);
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prog_done", prog_done, 0);
    chk("rst_err", err, 0);
    chk("rst_pc", pc, 0);
    #11 reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) write_mem(a, W'($urandom), 1'b1);
    // three-word program, done 4 cycles after each run
    write_mem(0, 16'h0040, 1'b1);
    write_mem(1, 16'h1234, 1'b1);
    write_mem(2, 16'h0008, 1'b1);
    lat = 4;
    r0 = run_cnt;
    d0 = done_cnt;
    launch(3);
    chk("basic_busy_running", busy, 1);
    finish_run("basic", 200);
    chk("basic_runs", run_cnt, r0 + 3);
    chk("basic_done", done_cnt, d0 + 1);
    chk("basic_pc", pc, 2);
    // zero length
    r0 = run_cnt;
    d0 = done_cnt;
    launch(0);
    chk("zero_busy", busy, 0);
    tick(3);
    chk("zero_busy_later", busy, 0);
    chk("zero_done", done_cnt, d0 + 1);
    chk("zero_runs", run_cnt, r0);
    chk("zero_queue", q.size(), 0);
    // done timeout
    r0 = run_cnt;
    resp_en = 1'b0;
    launch(2);
    wait_runs("timeout", r0 + 1, 20);
    rc = run_cyc;
    tick(rc + TIMEOUT + 1 - cyc);
    chk("timeout_err_early", err, 0);
    tick(1);
    chk("timeout_err", err, 1);
    chk("timeout_busy", busy, 1);
    tick(20);
    chk("timeout_no_run", run_cnt, r0 + 1);
    chk("timeout_err_sticky", err, 1);
    q.delete();
    resp_en = 1'b1;
    launch(2);
    chk("timeout_err_cleared", err, 0);
    finish_run("timeout_restart", 200);
    // abort in WAIT after word 1
    lat = 4;
    r0 = run_cnt;
    d0 = done_cnt;
    launch(3);
    wait_runs("abort", r0 + 2, 100);
    tick(run_cyc + 1 - cyc);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    q.delete();
    chk("abort_busy", busy, 0);
    tick(8);
    chk("abort_runs", run_cnt, r0 + 2);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_err", err, 0);
    write_mem(1, 16'hA5A5, 1'b1);
    launch(2);
    finish_run("abort_rerun", 200);
    // writes while busy are dropped, in IDLE they land
    lat = 3;
    launch(1);
    tick(1);
    write_mem(0, 16'hBEEF, 1'b0);
    finish_run("busy_write", 200);
    launch(1);
    finish_run("busy_write_rerun", 200);
    write_mem(0, 16'hBEEF, 1'b1);
    launch(1);
    finish_run("idle_write", 200);
    chk("idle_write_din", last_din, 16'hBEEF);
    // asynchronous reset mid-run
    r0 = run_cnt;
    launch(3);
    wait_runs("reset", r0 + 1, 100);
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_run", run, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_DIN", DIN, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_err", err, 0);
    tick(2);
    q.delete();
    trig_cyc = -1;
    #3 reset_n = 1'b1;
    @(negedge clk);
    launch(1);
    finish_run("post_reset", 200);
    // randomized runs, first one at full depth
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(0, 3)) write_mem($urandom_range(0, DEPTH - 1), W'($urandom), 1'b1);
      len = it == 0 ? DEPTH : $urandom_range(0, 8);
      lat = $urandom_range(1, 6);
      launch(len);
      finish_run("random", 2000);
      if (len > 0) chk("random_pc", pc, len - 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
